// File: rtl/dmg_pkg.sv
// Shared types and defaults for the DMG LCD capture path.
package dmg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LINE = 2'd1,
        ST_ACTIVE    = 2'd2
    } lcd_state_e;

    localparam int DEF_H_ACTIVE = 160;
    localparam int DEF_V_ACTIVE = 144;
    localparam int SYNC_DEPTH   = 2;

    // Synchronized view of one asynchronous control pin.
    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } sync_sig_t;

endpackage

// File: rtl/dmg_lcd_ctl.sv
// Line/frame tracking FSM that turns synchronized LCD events into VRAM writes.
module dmg_lcd_ctl
    import dmg_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE
) (
    input  logic        clk_12m,
    input  logic        rst,
    input  logic        clk_fall,
    input  logic        hs_rise,
    input  logic        vs_level,
    input  logic        ctl_level,
    input  logic [1:0]  pix_d,
    output logic [15:0] vramaddr,
    output logic [1:0]  vramdata,
    output logic        vramwe,
    output logic        frame_done,
    output logic        overrun,
    output lcd_state_e  state
);

    localparam logic [7:0] H_MAX = 8'(H_ACTIVE);
    localparam logic [7:0] V_END = 8'(V_ACTIVE);

    logic [7:0] xpos;
    logic [7:0] ypos;
    logic [7:0] y_next;

    assign y_next = vs_level ? 8'd0 : ypos + 8'd1;

    always_ff @(posedge clk_12m) begin
        if (rst) begin
            state      <= ST_IDLE;
            xpos       <= 8'd0;
            ypos       <= 8'd0;
            vramaddr   <= 16'd0;
            vramdata   <= 2'd0;
            vramwe     <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            vramwe     <= 1'b0;
            frame_done <= 1'b0;
            if (!ctl_level) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE, ST_WAIT_LINE: begin
                        if (hs_rise && vs_level) begin
                            state   <= ST_ACTIVE;
                            overrun <= 1'b0;
                            ypos    <= 8'd0;
                            // A pixel landing with the line start belongs to x=0 of the new line.
                            if (clk_fall) begin
                                vramwe   <= 1'b1;
                                vramaddr <= 16'd0;
                                vramdata <= pix_d;
                                xpos     <= 8'd1;
                            end else begin
                                xpos <= 8'd0;
                            end
                        end else if (hs_rise && state == ST_WAIT_LINE) begin
                            overrun <= 1'b1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (hs_rise) begin
                            ypos <= y_next;
                            if (!vs_level && y_next == V_END) begin
                                state      <= ST_WAIT_LINE;
                                frame_done <= 1'b1;
                                xpos       <= 8'd0;
                            end else if (clk_fall) begin
                                vramwe   <= 1'b1;
                                vramaddr <= {y_next, 8'd0};
                                vramdata <= pix_d;
                                xpos     <= 8'd1;
                            end else begin
                                xpos <= 8'd0;
                            end
                        end else if (clk_fall) begin
                            if (xpos < H_MAX) begin
                                vramwe   <= 1'b1;
                                vramaddr <= {ypos, xpos};
                                vramdata <= pix_d;
                                xpos     <= xpos + 8'd1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/sync_edge.sv
// Synchronizer for one asynchronous pin plus a history flop for rise/fall detection.
module sync_edge
    import dmg_pkg::*;
(
    input  logic clk_12m,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  hist_q;

    always_ff @(posedge clk_12m) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], din};
            hist_q <= sync_q[SYNC_DEPTH-1];
        end
    end

    assign level = sync_q[SYNC_DEPTH-1];
    assign rise  = level & ~hist_q;
    assign fall  = hist_q & ~level;

endmodule

// File: rtl/dmg_lcd_rx.sv
// DMG LCD bus receiver: synchronizes the panel pins into clk_12m and writes pixels to VRAM.
module dmg_lcd_rx
    import dmg_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE
) (
    input  logic        clk_12m,
    input  logic        rst,
    input  logic        lcd_clk,
    input  logic        lcd_hsync,
    input  logic        lcd_vsync,
    input  logic        lcd_d0,
    input  logic        lcd_d1,
    input  logic        lcd_control,
    output logic [15:0] vramaddr,
    output logic [1:0]  vramdata,
    output logic        vramwe,
    output logic        frame_done,
    output logic        overrun,
    output logic [1:0]  dbg_state,
    output logic [11:0] dbg_sync
);

    sync_sig_t clk_s, hs_s, vs_s, ctl_s;
    lcd_state_e ctl_state;

    // Data bits take the same depth as lcd_clk so a detected fall sees matching data.
    logic [SYNC_DEPTH-1:0] d0_q, d1_q;

    always_ff @(posedge clk_12m) begin
        if (rst) begin
            d0_q <= '0;
            d1_q <= '0;
        end else begin
            d0_q <= {d0_q[SYNC_DEPTH-2:0], lcd_d0};
            d1_q <= {d1_q[SYNC_DEPTH-2:0], lcd_d1};
        end
    end

    sync_edge u_sync_clk (
        .clk_12m (clk_12m), .rst (rst), .din (lcd_clk),
        .level (clk_s.level), .rise (clk_s.rise), .fall (clk_s.fall)
    );
    sync_edge u_sync_hs (
        .clk_12m (clk_12m), .rst (rst), .din (lcd_hsync),
        .level (hs_s.level), .rise (hs_s.rise), .fall (hs_s.fall)
    );
    sync_edge u_sync_vs (
        .clk_12m (clk_12m), .rst (rst), .din (lcd_vsync),
        .level (vs_s.level), .rise (vs_s.rise), .fall (vs_s.fall)
    );
    sync_edge u_sync_ctl (
        .clk_12m (clk_12m), .rst (rst), .din (lcd_control),
        .level (ctl_s.level), .rise (ctl_s.rise), .fall (ctl_s.fall)
    );

    dmg_lcd_ctl #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_ctl (
        .clk_12m    (clk_12m),
        .rst        (rst),
        .clk_fall   (clk_s.fall),
        .hs_rise    (hs_s.rise),
        .vs_level   (vs_s.level),
        .ctl_level  (ctl_s.level),
        .pix_d      ({d1_q[SYNC_DEPTH-1], d0_q[SYNC_DEPTH-1]}),
        .vramaddr   (vramaddr),
        .vramdata   (vramdata),
        .vramwe     (vramwe),
        .frame_done (frame_done),
        .overrun    (overrun),
        .state      (ctl_state)
    );

    assign dbg_state = ctl_state;
    assign dbg_sync  = {clk_s, hs_s, vs_s, ctl_s};

endmodule

// File: tb/tb_dmg_lcd_rx.sv
// Bench for dmg_lcd_rx: drives the LCD pins and checks VRAM writes against a line/frame model.
module tb_dmg_lcd_rx;
  import dmg_pkg::*;

  localparam int H_ACT = 160;
  localparam int V_ACT = 144;

  // clock / reset
  logic clk_12m = 1'b0;
  logic rst = 1'b1;
  logic lcd_clk = 1'b0, lcd_hsync = 1'b0, lcd_vsync = 1'b0;
  logic lcd_d0 = 1'b0, lcd_d1 = 1'b0, lcd_control = 1'b1;
  logic [15:0] vramaddr;
  logic [1:0]  vramdata;
  logic        vramwe, frame_done, overrun;
  logic [1:0]  dbg_state;
  logic [11:0] dbg_sync;

  always #5 clk_12m = ~clk_12m;

  dmg_lcd_rx dut (
    .clk_12m(clk_12m), .rst(rst), .lcd_clk(lcd_clk), .lcd_hsync(lcd_hsync),
    .lcd_vsync(lcd_vsync), .lcd_d0(lcd_d0), .lcd_d1(lcd_d1), .lcd_control(lcd_control),
    .vramaddr(vramaddr), .vramdata(vramdata), .vramwe(vramwe), .frame_done(frame_done),
    .overrun(overrun), .dbg_state(dbg_state), .dbg_sync(dbg_sync)
  );

  // scoreboard
  int n_cmp = 0, n_err = 0;
  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];
  int fd_count = 0;

  always @(negedge clk_12m) begin
    if (vramwe === 1'b1) got_q.push_back({vramaddr, vramdata});
    if (frame_done === 1'b1) fd_count++;
  end

  // reference model: frame/line position and sticky error, in panel terms
  bit panel = 1'b1, in_frame = 1'b0, waiting = 1'b0, exp_ovr = 1'b0;
  int my = 0, mx = 0, exp_fd = 0;

  function automatic void model_hs(input logic vs);
    if (!panel) return;
    if (vs) begin
      if (!in_frame) exp_ovr = 1'b0;
      in_frame = 1'b1; waiting = 1'b0; my = 0; mx = 0;
    end else if (in_frame) begin
      my++; mx = 0;
      if (my == V_ACT) begin in_frame = 1'b0; waiting = 1'b1; exp_fd++; end
    end else if (waiting) begin
      exp_ovr = 1'b1;
    end
  endfunction

  function automatic void model_px(input logic [1:0] d);
    if (!panel || !in_frame) return;
    if (mx < H_ACT) begin
      exp_q.push_back({my[7:0], mx[7:0], d});
      mx++;
    end else begin
      exp_ovr = 1'b1;
    end
  endfunction

  function automatic void model_panel(input bit on);
    panel = on;
    if (!on) begin in_frame = 1'b0; waiting = 1'b0; end
  endfunction

  function automatic void model_reset();
    in_frame = 1'b0; waiting = 1'b0; exp_ovr = 1'b0; my = 0; mx = 0;
  endfunction

  function automatic int first_diff();
    int n = (exp_q.size() < got_q.size()) ? exp_q.size() : got_q.size();
    for (int i = 0; i < n; i++) if (exp_q[i] !== got_q[i]) return i;
    if (exp_q.size() != got_q.size()) return n;
    return -1;
  endfunction

  function automatic logic [17:0] got_at(input int i);
    return (i >= 0 && i < got_q.size()) ? got_q[i] : 'x;
  endfunction

  function automatic logic [17:0] exp_at(input int i);
    return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 'x;
  endfunction

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk_12m);
  endtask

  task automatic px(input logic [1:0] d, input int hi, input int lo);
    lcd_clk = 1'b1;
    tick(hi);
    lcd_clk = 1'b0;
    {lcd_d1, lcd_d0} = d;
    model_px(d);
    tick(lo);
  endtask

  task automatic px_rand();
    px(2'($urandom_range(0, 3)), $urandom_range(1, 3), $urandom_range(1, 3));
  endtask

  task automatic hs(input logic vs);
    lcd_vsync = vs;
    lcd_hsync = 1'b1;
    model_hs(vs);
    tick(2);
    lcd_hsync = 1'b0;
    tick(1);
    lcd_vsync = 1'b0;
    tick(1);
  endtask

  task automatic clear_sb();
    got_q.delete();
    exp_q.delete();
  endtask

  // tests
  task automatic test_reset();
    int dix;
    rst = 1'b1;
    tick(3);
    n_cmp++;
    if ({vramaddr, vramdata, vramwe, frame_done, overrun, dbg_state} !== 23'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got addr=%h data=%h we=%b fd=%b ovr=%b st=%0d, want all 0",
               vramaddr, vramdata, vramwe, frame_done, overrun, dbg_state);
    end
    rst = 1'b0;
    repeat (20) begin lcd_clk = ~lcd_clk; tick(2); end
    n_cmp++;
    if ({vramaddr, vramdata, vramwe, frame_done, overrun, dbg_state} !== 23'd0) begin
      n_err++;
      $display("FAIL idle_outputs: got addr=%h data=%h we=%b fd=%b ovr=%b st=%0d, want all 0",
               vramaddr, vramdata, vramwe, frame_done, overrun, dbg_state);
    end
    dix = first_diff();
    n_cmp++;
    if (dix >= 0) begin
      n_err++;
      $display("FAIL idle_no_write: got %0d writes, want %0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_latency();
    clear_sb();
    hs(1'b1);
    lcd_clk = 1'b1;
    tick(3);
    lcd_clk = 1'b0;
    {lcd_d1, lcd_d0} = 2'b10;
    model_px(2'b10);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      n_cmp++;
      if (vramwe !== (k == 2)) begin
        n_err++;
        $display("FAIL latency_we_edge_n+%0d: got we=%b want %b", k, vramwe, (k == 2));
      end
      if (k == 2) begin
        n_cmp++;
        if ({vramaddr, vramdata} !== {16'h0000, 2'd2}) begin
          n_err++;
          $display("FAIL latency_addr_data: got %h/%0d want 0000/2", vramaddr, vramdata);
        end
      end
    end
    tick(2);
  endtask

  task automatic test_full_frame();
    int dix;
    clear_sb();
    hs(1'b1);
    for (int y = 0; y < V_ACT; y++) begin
      if (y > 0) hs(1'b0);
      for (int x = 0; x < H_ACT; x++) px(2'(x), 1, 1);
    end
    tick(2);
    n_cmp++;
    if (fd_count !== exp_fd) begin
      n_err++;
      $display("FAIL frame_done_early: got %0d pulses, want %0d before line end", fd_count, exp_fd);
    end
    hs(1'b0);
    tick(2);
    n_cmp++;
    if (fd_count !== exp_fd || exp_fd != 1) begin
      n_err++;
      $display("FAIL frame_done_count: got %0d pulses, want %0d", fd_count, exp_fd);
    end
    n_cmp++;
    if (got_q.size() != 23040) begin
      n_err++;
      $display("FAIL frame_write_count: got %0d, want 23040", got_q.size());
    end
    n_cmp++;
    if (got_at(got_q.size() - 1) !== {16'h8F9F, 2'd3}) begin
      n_err++;
      $display("FAIL frame_last_write: got %h, want %h", got_at(got_q.size() - 1), {16'h8F9F, 2'd3});
    end
    dix = first_diff();
    n_cmp++;
    if (dix >= 0) begin
      n_err++;
      $display("FAIL frame_writes: at %0d got %h (%0d) want %h (%0d)",
               dix, got_at(dix), got_q.size(), exp_at(dix), exp_q.size());
    end
    n_cmp++;
    if (dbg_state !== ST_WAIT_LINE) begin
      n_err++;
      $display("FAIL frame_end_state: got %0d want %0d", dbg_state, ST_WAIT_LINE);
    end
  endtask

  task automatic test_wait_line();
    int dix;
    clear_sb();
    hs(1'b0);
    px_rand();
    px_rand();
    n_cmp++;
    if (overrun !== exp_ovr || exp_ovr != 1'b1) begin
      n_err++;
      $display("FAIL wait_line_overrun: got %b want %b", overrun, exp_ovr);
    end
    n_cmp++;
    if (dbg_state !== ST_WAIT_LINE) begin
      n_err++;
      $display("FAIL wait_line_state: got %0d want %0d", dbg_state, ST_WAIT_LINE);
    end
    dix = first_diff();
    n_cmp++;
    if (dix >= 0) begin
      n_err++;
      $display("FAIL wait_line_no_write: got %0d writes want %0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_long_line();
    int dix;
    clear_sb();
    hs(1'b1);
    n_cmp++;
    if (overrun !== exp_ovr) begin
      n_err++;
      $display("FAIL longline_start_clear: got ovr=%b want %b", overrun, exp_ovr);
    end
    for (int y = 0; y < 6; y++) begin
      if (y > 0) hs(1'b0);
      if (y < 5) repeat ($urandom_range(1, 12)) px_rand();
      else repeat (165) px(2'($urandom_range(0, 3)), 1, 1);
    end
    tick(3);
    dix = first_diff();
    n_cmp++;
    if (dix >= 0) begin
      n_err++;
      $display("FAIL longline_writes: at %0d got %h (%0d) want %h (%0d)",
               dix, got_at(dix), got_q.size(), exp_at(dix), exp_q.size());
    end
    n_cmp++;
    if (overrun !== exp_ovr || exp_ovr != 1'b1) begin
      n_err++;
      $display("FAIL longline_overrun: got %b want %b", overrun, exp_ovr);
    end
    repeat (V_ACT - 5) hs(1'b0);
    tick(2);
    n_cmp++;
    if (overrun !== 1'b1 || fd_count !== exp_fd) begin
      n_err++;
      $display("FAIL longline_sticky: got ovr=%b fd=%0d want ovr=1 fd=%0d", overrun, fd_count, exp_fd);
    end
    hs(1'b1);
    n_cmp++;
    if (overrun !== exp_ovr || dbg_state !== ST_ACTIVE) begin
      n_err++;
      $display("FAIL longline_new_frame: got ovr=%b st=%0d want ovr=%b st=%0d",
               overrun, dbg_state, exp_ovr, ST_ACTIVE);
    end
  endtask

  task automatic test_panel_off();
    int dix;
    clear_sb();
    for (int y = 1; y <= 10; y++) begin
      hs(1'b0);
      if (y == 9) repeat (162) px(2'($urandom_range(0, 3)), 1, 1);
      else if (y == 10) repeat (80) px_rand();
      else repeat ($urandom_range(1, 6)) px_rand();
    end
    lcd_control = 1'b0;
    model_panel(1'b0);
    tick(4);
    n_cmp++;
    if (dbg_state !== ST_IDLE || overrun !== exp_ovr) begin
      n_err++;
      $display("FAIL panel_off_state: got st=%0d ovr=%b want st=%0d ovr=%b",
               dbg_state, overrun, ST_IDLE, exp_ovr);
    end
    repeat (3) px_rand();
    hs(1'b1);
    repeat (2) px_rand();
    lcd_control = 1'b1;
    model_panel(1'b1);
    tick(4);
    hs(1'b0);
    repeat (3) px_rand();
    hs(1'b1);
    repeat (3) px_rand();
    tick(3);
    dix = first_diff();
    n_cmp++;
    if (dix >= 0) begin
      n_err++;
      $display("FAIL panel_off_writes: at %0d got %h (%0d) want %h (%0d)",
               dix, got_at(dix), got_q.size(), exp_at(dix), exp_q.size());
    end
    n_cmp++;
    if (got_at(got_q.size() - 3) !== {16'h0000, exp_at(exp_q.size() - 3)} ||
        exp_at(exp_q.size() - 3) !== {16'h0000, exp_at(exp_q.size() - 3)}) begin
      n_err++;
      $display("FAIL panel_resume_addr: got %h want address 0000", got_at(got_q.size() - 3));
    end
    n_cmp++;
    if (overrun !== exp_ovr) begin
      n_err++;
      $display("FAIL panel_resume_ovr: got %b want %b", overrun, exp_ovr);
    end
  endtask

  task automatic test_collision();
    int dix;
    logic [1:0] d;
    clear_sb();
    for (int y = 1; y <= 3; y++) begin
      hs(1'b0);
      repeat ($urandom_range(2, 6)) px_rand();
    end
    lcd_clk = 1'b1;
    tick(3);
    d = 2'($urandom_range(0, 3));
    lcd_hsync = 1'b1;
    lcd_vsync = 1'b0;
    lcd_clk = 1'b0;
    {lcd_d1, lcd_d0} = d;
    model_hs(1'b0);
    model_px(d);
    tick(2);
    lcd_hsync = 1'b0;
    tick(2);
    px_rand();
    tick(3);
    dix = first_diff();
    n_cmp++;
    if (dix >= 0) begin
      n_err++;
      $display("FAIL collision_writes: at %0d got %h (%0d) want %h (%0d)",
               dix, got_at(dix), got_q.size(), exp_at(dix), exp_q.size());
    end
    n_cmp++;
    if (got_at(got_q.size() - 2) !== {16'h0400, d} || got_at(got_q.size() - 1) >> 2 !== 18'(16'h0401)) begin
      n_err++;
      $display("FAIL collision_addr: got %h,%h want 0400,0401",
               got_at(got_q.size() - 2) >> 2, got_at(got_q.size() - 1) >> 2);
    end
  endtask

  task automatic test_reset_midline();
    int dix;
    clear_sb();
    lcd_clk = 1'b1;
    tick(3);
    lcd_clk = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    model_reset();
    n_cmp++;
    if ({vramaddr, vramdata, vramwe, frame_done, overrun, dbg_state} !== 23'd0) begin
      n_err++;
      $display("FAIL midline_reset_outputs: got addr=%h we=%b ovr=%b st=%0d, want all 0",
               vramaddr, vramwe, overrun, dbg_state);
    end
    rst = 1'b0;
    tick(4);
    repeat (2) px_rand();
    hs(1'b0);
    repeat (2) px_rand();
    hs(1'b1);
    repeat (2) px_rand();
    tick(3);
    dix = first_diff();
    n_cmp++;
    if (dix >= 0) begin
      n_err++;
      $display("FAIL midline_reset_writes: at %0d got %h (%0d) want %h (%0d)",
               dix, got_at(dix), got_q.size(), exp_at(dix), exp_q.size());
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_latency();
    test_full_frame();
    test_wait_line();
    test_long_line();
    test_panel_off();
    test_collision();
    test_reset_midline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmg_lcd_rx.md
DMG_LCD_RX -- requirements
Module: dmg_lcd_rx

Interface
REQ-001 Parameter H_ACTIVE, default 160: pixels per line written to VRAM.
REQ-002 Parameter V_ACTIVE, default 144: lines per frame written to VRAM.
REQ-003 clk_12m  in  1  sole clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 lcd_clk  in  1  DMG pixel clock, asynchronous; pixel valid at its falling edge.
REQ-006 lcd_hsync  in  1  line strobe, asynchronous; rising edge starts a line.
REQ-007 lcd_vsync  in  1  frame marker, asynchronous; high at the hsync rising edge of line 0.
REQ-008 lcd_d0, lcd_d1  in  1 each  pixel data bits, asynchronous.
REQ-009 lcd_control  in  1  LCD enable, asynchronous; low means panel off.
REQ-010 vramaddr  out  16  write address {ypos[7:0], xpos[7:0]}.
REQ-011 vramdata  out  2  pixel value {d1, d0}.
REQ-012 vramwe  out  1  one-cycle write strobe.
REQ-013 frame_done  out  1  one-cycle pulse after line V_ACTIVE-1 completes.
REQ-014 overrun  out  1  sticky error: too many pixels in a line or lines in a frame.

Function
REQ-015 Every asynchronous input SHALL pass through a 2-flop synchronizer, followed by one history flop for edge detection.
REQ-016 The pipeline index counts from edge 0, the first clk_12m edge that samples the new pin level.
REQ-017 A lcd_clk falling edge SHALL assert vramwe during the cycle after edge 2, for exactly one cycle.
REQ-018 vramdata SHALL be the lcd_d1/lcd_d0 values that passed through the same synchronizer depth as lcd_clk.
REQ-019 States: IDLE, WAIT_LINE, ACTIVE. Reset enters IDLE.
REQ-020 IDLE -> ACTIVE on an hsync rise while synced vsync=1 and control=1; this sets ypos=0 and xpos=0.
REQ-021 ACTIVE: each lcd_clk fall with xpos<H_ACTIVE writes once, then xpos++.
REQ-022 ACTIVE: a lcd_clk fall with xpos>=H_ACTIVE is not written; overrun is set.
REQ-023 ACTIVE, hsync rise, vsync=0: xpos=0, ypos++.
REQ-024 ACTIVE, hsync rise, vsync=1: xpos=0, ypos=0 (resync).
REQ-025 When ypos reaches V_ACTIVE, go to WAIT_LINE, pulse frame_done once, and perform no writes.
REQ-026 WAIT_LINE -> ACTIVE on an hsync rise with vsync=1, ypos=0.
REQ-027 WAIT_LINE: an hsync rise with vsync=0 sets overrun and stays in WAIT_LINE.
REQ-028 Any state: synced control=0 forces IDLE with no write that cycle; overrun is kept.
REQ-029 Simultaneous hsync rise and lcd_clk fall in one cycle: the line start takes priority.
REQ-030 In that case the pixel is written at xpos=0 of the new line, and xpos becomes 1.
REQ-031 overrun SHALL clear only on reset or on entry to ACTIVE from IDLE/WAIT_LINE with vsync=1.
REQ-032 xpos and ypos are 8-bit; vramaddr[15:8]=ypos, vramaddr[7:0]=xpos, both registered with vramwe.
REQ-033 vramaddr and vramdata SHALL hold their values when vramwe=0.

Reset
REQ-034 On rst=1 at a clock edge, the following SHALL take value 0:
- all synchronizer and history flops
- xpos, ypos
- vramaddr, vramdata, vramwe
- frame_done, overrun
REQ-035 On rst=1 at a clock edge, the state SHALL be IDLE.
REQ-036 Reset asserted mid-line SHALL abort the line; no write occurs in the cycle after the reset edge.
REQ-037 After reset, no write SHALL occur before a new vsync-qualified hsync rise.

Structure
REQ-038 Package dmg_pkg SHALL hold:
- the state enum
- H_ACTIVE/V_ACTIVE defaults
- the sync depth constant (2)
REQ-039 dmg_lcd_ctl SHALL reuse the H_ACTIVE/V_ACTIVE defaults from dmg_pkg.
REQ-040 Sub-module sync_edge (synchronizer plus rise/fall detect) SHALL be instantiated once per control input.
REQ-041 Data bits SHALL use bare synchronizers matching the sync_edge depth.

Verification
REQ-042 Reset and idle:
- stimulus: rst high 3 cycles, then 20 lcd_clk toggles with no hsync
- response: vramwe never asserts; all outputs 0
REQ-043 Full frame:
- stimulus: control=1; vsync+hsync; 144 lines of 160 pixels, pixel value = x[1:0]
- response: exactly 23040 writes; last address 0x8F9F
- response: frame_done pulses once, after line 143 ends
REQ-044 Latency:
- stimulus: lcd_clk falls, first sampled low at edge N, d1d0=2'b10
- response: vramwe=1 only in cycle N+3; vramdata=2
REQ-045 Long line:
- stimulus: 165 pixels on line 5
- response: writes at x=0..159 only; overrun=1
- response: next vsync frame start clears overrun
REQ-046 Panel off:
- stimulus: control drops at x=80 of line 10
- response: state IDLE; no further writes until vsync+hsync
- response: then writes resume at address 0x0000
REQ-047 Collision:
- stimulus: hsync rise and lcd_clk fall synchronized in the same cycle, line 3
- response: write to 0x0400; next pixel to 0x0401
